// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC generation, imem request/response, FWFT prefetch FIFO
// Optional feature macro: IF_JUMP_PREDECODE_EN (redirect fetch on returning j instructions).
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] next_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  input  logic        id_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  // PC belonging to the next response that will be kept (responses return in order)
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q [DEPTH];

  logic [CW:0]   credit_used;
  logic          gnt_fire;
  logic          push;
  logic          pop;
  logic          jump_hit;
  logic [31:0]   jump_target;
  logic [31:0]   redirect_aligned;
  logic          unused_redirect_lsbs;

  assign redirect_aligned     = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Outstanding requests reserve a FIFO slot, so the FIFO can never overflow
  assign credit_used = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req    = !reset && (state_q == S_RUN) && (credit_used < DEPTH_W);
  assign imem_addr   = fetch_pc_q;
  assign gnt_fire    = imem_req && imem_gnt;

  // A redirect discards both the incoming word and the head consumption
  assign push = imem_rvalid && (drop_q == '0) && !redirect;
  assign pop  = if_valid && id_ready && !redirect;

  assign if_valid         = (count_q != '0);
  assign next_instruction = if_valid ? instr_mem_q[rd_ptr_q] : NOP_WORD;
  assign if_pc            = pc_mem_q[rd_ptr_q];
  assign if_pc_plus4      = if_pc + 32'd4;

`ifdef IF_JUMP_PREDECODE_EN
  logic [3:0] jump_region;
  // Upper nibble of pc+4: carry out of bits [27:2] bumps the region
  assign jump_region = resp_pc_q[31:28] + {3'b000, &resp_pc_q[27:2]};
  assign jump_hit    = push && (imem_rdata[31:26] == 6'b000010);
  assign jump_target = {jump_region, imem_rdata[25:0], 2'b00};
`else
  assign jump_hit    = 1'b0;
  assign jump_target = 32'h0000_0000;
`endif

  // Next state: issue/response/FIFO bookkeeping, then redirects override
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CW'(gnt_fire) - CW'(imem_rvalid);
    count_d    = count_q + CW'(push) - CW'(pop);

    if (gnt_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (imem_rvalid && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
    if (push) begin
      wr_ptr_d  = wr_ptr_q + AW'(1);
      resp_pc_d = resp_pc_q + 32'd4;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if ((state_q == S_FLUSH) && (drop_d == '0)) begin
      state_d = S_RUN;
    end

    if (redirect) begin
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      drop_d     = outst_d;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      state_d    = (outst_d != '0) ? S_FLUSH : S_RUN;
    end else if (jump_hit) begin
      // Jump word itself and older entries stay in the FIFO
      fetch_pc_d = jump_target;
      resp_pc_d  = jump_target;
      drop_d     = outst_d;
      state_d    = (outst_d != '0) ? S_FLUSH : S_RUN;
    end
  end

  // Control registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage; occupancy is tracked by count_q so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard testbench for instruction_fetch
`timescale 1ns/1ps
module tb_instruction_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, imem_req, imem_gnt, imem_rvalid, redirect, if_valid, id_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, next_instruction, if_pc, if_pc_plus4;

  logic        w_reset, w_req, w_gnt, w_rvalid, w_redirect, w_valid, w_id_ready;
  logic [31:0] w_addr, w_rdata, w_redirect_pc, w_instr, w_pc, w_pc_plus4;

  instruction_fetch dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .next_instruction(next_instruction),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_valid(if_valid), .id_ready(id_ready)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(w_reset), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(w_gnt), .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc), .next_instruction(w_instr),
    .if_pc(w_pc), .if_pc_plus4(w_pc_plus4), .if_valid(w_valid), .id_ready(w_id_ready)
  );

  int checks = 0;
  int passes = 0;
  int pops = 0;
  int w_pops = 0;
  int cyc = 0;
  logic resp_en = 1'b0;
  logic jump_on = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] w_exp_q[$];
  logic [31:0] pending[$];
  logic [31:0] gnt_log[$];
  logic [31:0] w_log[$];
  int pop_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (jump_on && (a == 32'h0000_0010)) return 32'h0800_0040;
    return {6'b111000, a[25:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%h expected=%h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%b expected=%b", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pops(input int target, input int budget, input string name);
    int k = 0;
    while ((pops < target) && (k < budget)) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk1(name, pops >= target, 1'b1);
  endtask

  task automatic do_reset();
    id_ready = 1'b0;
    redirect = 1'b0;
    reset    = 1'b1;
    step(2);
    @(negedge clk);
    chk1("rst_imem_req", imem_req, 1'b0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk("rst_next_instruction", next_instruction, 32'h0000_0000);
    exp_q.delete();
    gnt_log.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Main instruction memory: grant sampled mid-cycle, in-order response one cycle later
  initial begin
    logic g, rs;
    logic [31:0] ga;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      rs = reset;
      g  = imem_req && imem_gnt && !reset;
      ga = imem_addr;
      @(posedge clk);
      #1;
      if (rs) pending.delete();
      if (g) begin
        pending.push_back(ga);
        gnt_log.push_back(ga);
      end
      if (resp_en && (pending.size() > 0)) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memword(pending.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
    end
  end

  // Wrap-instance memory: always grants, always answers next cycle
  initial begin
    logic g;
    logic [31:0] ga;
    w_gnt = 1'b1;
    w_rvalid = 1'b0;
    w_rdata = 32'h0;
    w_redirect = 1'b0;
    w_redirect_pc = 32'h0;
    forever begin
      @(negedge clk);
      g  = w_req && !w_reset;
      ga = w_addr;
      @(posedge clk);
      #1;
      w_rvalid = g;
      w_rdata  = memword(ga);
      if (g) w_log.push_back(ga);
    end
  end

  // Main monitor: every consumed head is compared against the scoreboard
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!reset && if_valid && id_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL sb_unexpected: actual if_pc=%h expected no delivery", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_if_pc", if_pc, e);
          chk("sb_instruction", next_instruction, memword(e));
          chk("sb_if_pc_plus4", if_pc_plus4, e + 32'd4);
        end
        pops++;
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Wrap-instance monitor
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!w_reset && w_valid && w_id_ready) begin
        if (w_exp_q.size() == 0) begin
          checks++;
          $display("FAIL wsb_unexpected: actual if_pc=%h expected no delivery", w_pc);
        end else begin
          e = w_exp_q.pop_front();
          chk("wsb_if_pc", w_pc, e);
          chk("wsb_instruction", w_instr, memword(e));
          chk("wsb_if_pc_plus4", w_pc_plus4, e + 32'd4);
        end
        w_pops++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int nlog;
    int k;
    reset = 1'b1; imem_gnt = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    w_reset = 1'b1; w_id_ready = 1'b0;

    // Streaming: addresses 0,4,8 and back-to-back delivery
    imem_gnt = 1'b1; resp_en = 1'b1;
    do_reset();
    for (int i = 0; i < 32; i++) exp_q.push_back(32'(i * 4));
    base = pops;
    id_ready = 1'b1;
    wait_pops(base + 8, 40, "t1_stream_timeout");
    if (pop_cyc.size() >= base + 3) begin
      chk("t1_back_to_back_1", 32'(pop_cyc[base + 1] - pop_cyc[base]), 32'd1);
      chk("t1_back_to_back_2", 32'(pop_cyc[base + 2] - pop_cyc[base + 1]), 32'd1);
    end
    chk1("t1_grants_seen", gnt_log.size() >= 3, 1'b1);
    if (gnt_log.size() >= 3) begin
      chk("t1_addr_1", gnt_log[1], 32'h4);
      chk("t1_addr_2", gnt_log[2], 32'h8);
    end

    // Back-pressure: exactly DEPTH grants, then drain in order and resume
    do_reset();
    for (int i = 0; i < 32; i++) exp_q.push_back(32'(i * 4));
    step(12);
    chk("t2_grant_count", gnt_log.size(), 32'd4);
    @(negedge clk);
    chk1("t2_req_stalled", imem_req, 1'b0);
    chk1("t2_if_valid", if_valid, 1'b1);
    chk("t2_head_pc", if_pc, 32'h0);
    @(posedge clk);
    #1;
    base = pops;
    id_ready = 1'b1;
    wait_pops(base + 4, 10, "t2_drain_timeout");
    wait_pops(base + 8, 30, "t2_resume_timeout");
    chk1("t2_issue_resumed", gnt_log.size() > 4, 1'b1);
    if (gnt_log.size() > 4) chk("t2_addr_after_drain", gnt_log[4], 32'h10);

    // Redirect with two responses outstanding
    imem_gnt = 1'b0; resp_en = 1'b0;
    do_reset();
    id_ready = 1'b1;
    imem_gnt = 1'b1;
    step(2);
    imem_gnt = 1'b0;
    step(1);
    chk("t3_grants", gnt_log.size(), 32'd2);
    @(negedge clk);
    chk1("t3_req_held", imem_req, 1'b1);
    chk("t3_addr_held", imem_addr, 32'h8);
    @(posedge clk);
    #1;
    nlog = gnt_log.size();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    step(1);
    redirect = 1'b0;
    @(negedge clk);
    chk1("t3_flush_no_req", imem_req, 1'b0);
    chk1("t3_flush_empty", if_valid, 1'b0);
    @(posedge clk);
    #1;
    base = pops;
    imem_gnt = 1'b1; resp_en = 1'b1;
    wait_pops(base + 4, 30, "t3_refetch_timeout");
    chk1("t3_regrant_seen", gnt_log.size() > nlog, 1'b1);
    if (gnt_log.size() > nlog) chk("t3_first_addr", gnt_log[nlog], 32'h100);

    // Redirect coincident with a response and a head pop
    do_reset();
    for (int i = 0; i < 32; i++) exp_q.push_back(32'(i * 4));
    base = pops;
    id_ready = 1'b1;
    wait_pops(base + 3, 20, "t4_stream_timeout");
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h200 + 32'(i * 4));
    @(negedge clk);
    chk1("t4_rvalid_coincident", imem_rvalid, 1'b1);
    chk1("t4_pop_coincident", if_valid, 1'b1);
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    chk1("t4_fifo_empty", if_valid, 1'b0);
    chk("t4_nop_word", next_instruction, 32'h0000_0000);
    @(posedge clk);
    #1;
    base = pops;
    wait_pops(base + 4, 30, "t4_refetch_timeout");

`ifdef IF_JUMP_PREDECODE_EN
    // Jump predecode: j at 0x10 targets 0x100, wrong-path words dropped
    jump_on = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    for (int i = 0; i < 12; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    base = pops;
    id_ready = 1'b1;
    wait_pops(base + 10, 40, "t6_jump_timeout");
    id_ready = 1'b0;
    step(1);
    jump_on = 1'b0;
`endif

    // PC wrap on the second instance
    do_reset();
    w_reset = 1'b0;
    step(10);
    chk("t5_grant_count", w_log.size(), 32'd4);
    if (w_log.size() == 4) begin
      chk("t5_addr_0", w_log[0], 32'hFFFF_FFF8);
      chk("t5_addr_1", w_log[1], 32'hFFFF_FFFC);
      chk("t5_addr_2", w_log[2], 32'h0000_0000);
      chk("t5_addr_3", w_log[3], 32'h0000_0004);
    end
    w_exp_q.push_back(32'hFFFF_FFF8);
    w_exp_q.push_back(32'hFFFF_FFFC);
    for (int i = 0; i < 6; i++) w_exp_q.push_back(32'(i * 4));
    w_id_ready = 1'b1;
    k = 0;
    while ((w_pops < 4) && (k < 20)) begin
      @(posedge clk);
      #1;
      k++;
    end
    w_id_ready = 1'b0;
    chk1("t5_drain_timeout", w_pops >= 4, 1'b1);

    step(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
